seg_scan_driver: RTL and testbench
==================================

Name: seg_scan_driver

Overview:
- Time-multiplexed driver for a common-anode, multi-digit 7-segment display.
- Captures a packed hex value, per-digit blank mask and per-digit decimal-point mask once per frame.
- Scans one digit at a time: drives its anode low and its active-low segment pattern.
- Sits between game logic (score, timer, mole count) and the board display pins.

Parameters:
- NUM_DIGITS, 4, digits scanned; legal range 2..8.
- DIV_COUNT, 100000, clock cycles each digit is lit; 1 ms at 100 MHz; must be >= 2.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- value  input  4*NUM_DIGITS  hex nibbles; digit 0 = bits [3:0] = rightmost
- blank  input  NUM_DIGITS  1 = digit dark
- dp  input  NUM_DIGITS  1 = decimal point lit on that digit
- an  output  NUM_DIGITS  anode enables, active-low
- seg  output  7  segments, active-low, seg[6]=g … seg[0]=a
- dp_n  output  1  decimal point, active-low
- frame_tick  output  1  one-cycle pulse at each frame start

Behaviour:
- This design uses one clock and a synchronous, active-high reset: clk and rst.
- Reset values:
  - cnt=0, idx=0.
  - shadow_value=0, shadow_blank=all ones, shadow_dp=0.
  - an=all ones, seg=7'b1111111, dp_n=1, frame_tick=0.
- Prescaler:
  - cnt counts 0..DIV_COUNT-1 and wraps to 0.
  - tick = (cnt==DIV_COUNT-1).
- Digit index:
  - idx has width max(1,$clog2(NUM_DIGITS)).
  - On tick, idx increments; it wraps from NUM_DIGITS-1 to 0. No out-of-range index is ever reached.
- Frame snapshot:
  - On the edge where tick=1 and idx==NUM_DIGITS-1, shadow_value/blank/dp load from the inputs.
  - idx becomes 0 on that same edge.
  - Inputs are ignored at all other times, so there is no tearing within a frame.
- Output register:
  - an, seg and dp_n are registered every cycle from the current idx and shadow.
  - Latency is exactly 1 cycle after idx or shadow changes.
- Lit digit (shadow_blank[idx]=0):
  - an has only bit idx low.
  - seg = hex pattern of the idx nibble.
  - dp_n = ~shadow_dp[idx].
- Blanked digit: an = all ones, seg = 7'b1111111, dp_n = 1.
- frame_tick:
  - Registered.
  - High for exactly the one cycle after the snapshot edge, i.e. the first cycle idx==0 holds the new frame.
- Display is dark from reset until the first snapshot, NUM_DIGITS*DIV_COUNT cycles after reset release.
- rst mid-scan: on the next edge all state returns to reset values and outputs go dark. No partial frame is retained.
- Segment table, active-low gfedcba:
  - 0:1000000, 1:1111001, 2:0100100, 3:0110000
  - 4:0011001, 5:0010010, 6:0000010, 7:1111000
  - 8:0000000, 9:0010000, A:0001000, b:0000011
  - C:1000110, d:0100001, E:0000110, F:0001110

Optional Feature:
- Macro: SEG_LEADING_ZERO_BLANK_EN.
- Defined:
  - Digit k (k>=1) is additionally blanked when its shadow nibble and every higher digit's nibble are 0.
  - Digit 0 is never suppressed; value 0 shows a single "0".
  - Suppression is computed from shadow contents only.
- Undefined: only the blank mask blanks digits; zeros are displayed.

Decomposition:
- Package seg_scan_pkg holds:
  - the 16-entry segment constant table;
  - SEG_OFF = 7'b1111111;
  - the localparam function for idx width.
- Sub-module seg_scan_prescaler contains cnt and outputs tick.
- Top-level contains idx, shadow registers, leading-zero logic and the output register.

Test Plan (bench uses NUM_DIGITS=4, DIV_COUNT=4):
- Reset release, value=16'h1234, blank=0 → all outputs dark for 16 cycles, then frame_tick pulses once. Next cycle: an=4'b1110, seg=7'b0011001 ("4"), held 4 cycles. Then an=1101, seg=0110000; then 1011 / 0100100; then 0111 / 1111001.
- value changes to 16'hABCD mid-frame → current frame keeps showing 1234. The next frame shows D/C/b/A (0100001, 1000110, 0000011, 0001000).
- blank=4'b0100, dp=4'b0001 → digit 2 slot gives an=1111 and seg=1111111. Digit 0 gives dp_n=0; all other digits give dp_n=1.
- rst asserted for 1 cycle while idx=2 → next cycle an=1111, frame_tick=0. Scanning restarts from the reset state.
- frame_tick period → exactly one pulse every 16 cycles and never two consecutive high cycles.
- With SEG_LEADING_ZERO_BLANK_EN, value=16'h0070 → digits 3 and 2 dark; digit 1 shows "7" (1111000); digit 0 shows "0" (1000000).
- With SEG_LEADING_ZERO_BLANK_EN, value=16'h0000 → only digit 0 lit, showing "0".

Source files
------------

// File: rtl/seg_scan_pkg.sv
// -----------------------------------------------------------------------------
// seg_scan_pkg
// Shared constants and helpers for the multiplexed 7-segment scan driver.
//   SEG_TABLE  : 16-entry hex -> active-low gfedcba pattern (index = nibble)
//   SEG_OFF    : all segments dark
//   idx_width  : digit-index width, max(1, clog2(num_digits))
//   hex_to_seg : table lookup for one nibble
// -----------------------------------------------------------------------------
package seg_scan_pkg;

  // All segments off (active-low).
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Packed so element [n] is the pattern for nibble n; listed F down to 0.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  // Digit-index width; a single-bit index is kept even for tiny displays.
  function automatic int idx_width(input int num_digits);
    if ($clog2(num_digits) < 1) begin
      return 1;
    end else begin
      return $clog2(num_digits);
    end
  endfunction

  // Hex nibble to active-low segment pattern.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/seg_scan_prescaler.sv
// -----------------------------------------------------------------------------
// seg_scan_prescaler
// Free-running divider that sets how long each digit stays lit.
// cnt runs 0..DIV_COUNT-1 and wraps; tick is high while cnt is at its last
// value, so the digit index advances on the edge that wraps the counter.
//
// Ports:
//   clk   in   system clock
//   rst   in   synchronous reset, active-high
//   tick  out  one-cycle strobe every DIV_COUNT cycles (combinational on cnt)
//
// Parameters:
//   DIV_COUNT  clock cycles per digit slot, must be >= 2
// -----------------------------------------------------------------------------
module seg_scan_prescaler #(
  parameter int DIV_COUNT = 100000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int               CNT_W   = $clog2(DIV_COUNT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV_COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic [CNT_W-1:0] cnt_r;

  // Slot counter: wraps at DIV_COUNT-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= CNT_ZERO;
    end else if (cnt_r == CNT_MAX) begin
      cnt_r <= CNT_ZERO;
    end else begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  assign tick = (cnt_r == CNT_MAX);

endmodule

// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
// Time-multiplexed driver for a common-anode multi-digit 7-segment display.
// The value / blank / dp inputs are captured into shadow registers once per
// frame (on the slot tick that ends the last digit), so a frame never mixes
// old and new data. One digit is lit at a time; an, seg and dp_n are
// registered from the current index and the shadow state.
//
// Ports:
//   clk         in   system clock
//   rst         in   synchronous reset, active-high
//   value       in   4*NUM_DIGITS hex nibbles, digit 0 = bits [3:0] (rightmost)
//   blank       in   NUM_DIGITS, 1 = digit dark
//   dp          in   NUM_DIGITS, 1 = decimal point lit on that digit
//   an          out  NUM_DIGITS anode enables, active-low
//   seg         out  7 segments, active-low, seg[6]=g .. seg[0]=a
//   dp_n        out  decimal point, active-low
//   frame_tick  out  one-cycle pulse, first cycle the new frame is in shadow
//
// Parameters:
//   NUM_DIGITS  digits scanned, 2..8
//   DIV_COUNT   clock cycles each digit is lit, >= 2
//
// Build option:
//   SEG_LEADING_ZERO_BLANK_EN  when defined, digit k>=1 is also dark if its
//   shadow nibble and every higher nibble are zero (digit 0 always shows).
// -----------------------------------------------------------------------------
module seg_scan_driver
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIV_COUNT  = 100000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic [NUM_DIGITS-1:0]     blank,
  input  logic [NUM_DIGITS-1:0]     dp,
  output logic [NUM_DIGITS-1:0]     an,
  output logic [6:0]                seg,
  output logic                      dp_n,
  output logic                      frame_tick
);

  localparam int                    IDX_W    = idx_width(NUM_DIGITS);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [IDX_W-1:0]      IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0]      IDX_ZERO = IDX_W'(0);
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{1'b1}};
  localparam logic [NUM_DIGITS-1:0] AN_ONE   = NUM_DIGITS'(1);
  localparam logic [NUM_DIGITS-1:0] MASK_ZERO = {NUM_DIGITS{1'b0}};

  logic                      tick_s;
  logic                      frame_load_s;
  logic [IDX_W-1:0]          idx_r;
  logic [4*NUM_DIGITS-1:0]   shadow_value_r;
  logic [NUM_DIGITS-1:0]     shadow_blank_r;
  logic [NUM_DIGITS-1:0]     shadow_dp_r;
  logic [NUM_DIGITS-1:0]     suppress_s;
  logic [3:0]                nibble_s;
  logic                      dark_s;
  logic [NUM_DIGITS-1:0]     an_next_s;
  logic [6:0]                seg_next_s;
  logic                      dp_n_next_s;

  seg_scan_prescaler #(
    .DIV_COUNT (DIV_COUNT)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick_s)
  );

  // The last slot of a frame is ending: capture the next frame's inputs.
  assign frame_load_s = tick_s && (idx_r == IDX_LAST);

  // Digit index: advances once per slot and wraps after the last digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r <= IDX_ZERO;
    end else if (tick_s) begin
      if (idx_r == IDX_LAST) begin
        idx_r <= IDX_ZERO;
      end else begin
        idx_r <= idx_r + IDX_ONE;
      end
    end else begin
      idx_r <= idx_r;
    end
  end

  // Frame shadow: inputs are only sampled at the frame boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_value_r <= {(4*NUM_DIGITS){1'b0}};
      shadow_blank_r <= {NUM_DIGITS{1'b1}};
      shadow_dp_r    <= MASK_ZERO;
    end else if (frame_load_s) begin
      shadow_value_r <= value;
      shadow_blank_r <= blank;
      shadow_dp_r    <= dp;
    end else begin
      shadow_value_r <= shadow_value_r;
      shadow_blank_r <= shadow_blank_r;
      shadow_dp_r    <= shadow_dp_r;
    end
  end

  // Frame pulse lands on the first cycle idx==0 holds the freshly loaded frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_load_s;
    end
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic run_zero_s;

  // Leading-zero suppression: walk down from the top digit while nibbles are
  // zero. Digit 0 is excluded so a zero value still shows a single "0".
  always_comb begin
    suppress_s = MASK_ZERO;
    run_zero_s = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      run_zero_s    = run_zero_s & (shadow_value_r[4*k +: 4] == 4'h0);
      suppress_s[k] = run_zero_s;
    end
  end
`else
  // No zero suppression: only the blank mask darkens digits.
  always_comb begin
    suppress_s = MASK_ZERO;
  end
`endif

  // Next output pattern for the digit currently being scanned.
  always_comb begin
    nibble_s    = shadow_value_r[{idx_r, 2'b00} +: 4];
    dark_s      = shadow_blank_r[idx_r] | suppress_s[idx_r];
    an_next_s   = AN_OFF;
    seg_next_s  = SEG_OFF;
    dp_n_next_s = 1'b1;
    if (dark_s) begin
      an_next_s   = AN_OFF;
      seg_next_s  = SEG_OFF;
      dp_n_next_s = 1'b1;
    end else begin
      an_next_s   = ~(AN_ONE << idx_r);
      seg_next_s  = hex_to_seg(nibble_s);
      dp_n_next_s = ~shadow_dp_r[idx_r];
    end
  end

  // Output register: pins change exactly one cycle after idx or shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      an   <= AN_OFF;
      seg  <= SEG_OFF;
      dp_n <= 1'b1;
    end else begin
      an   <= an_next_s;
      seg  <= seg_next_s;
      dp_n <= dp_n_next_s;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_driver
// Self-checking bench for seg_scan_driver with NUM_DIGITS=4, DIV_COUNT=4.
// A cycle-count reference model (edges since reset) predicts every output on
// every cycle; a vector table checks whole frames slot by slot; hand-written
// sequences cover first-frame latency and reset mid-scan; a random phase
// drives changing inputs and occasional resets against the same model.
// -----------------------------------------------------------------------------
module tb_seg_scan_driver;

  localparam int ND    = 4;
  localparam int DC    = 4;
  localparam int FRAME = ND * DC;
  localparam int NVEC  = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  blank;
  logic [3:0]  dp;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;
  logic        frame_tick;

  seg_scan_driver #(
    .NUM_DIGITS (ND),
    .DIV_COUNT  (DC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .blank      (blank),
    .dp         (dp),
    .an         (an),
    .seg        (seg),
    .dp_n       (dp_n),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state.
  int          c;        // rising edges since reset released
  logic [15:0] m_val;
  logic [3:0]  m_blank;
  logic [3:0]  m_dp;
  int          last_ft;
  logic        prev_ft;
  logic [6:0]  seg_ref [16];

  typedef struct packed {
    logic [15:0]     value;
    logic [3:0]      blank;
    logic [3:0]      dp;
    logic [3:0][3:0] an;    // [slot]
    logic [3:0][6:0] seg;   // [slot]
    logic [3:0]      dpn;   // [slot]
  } vec_t;

  vec_t tbl [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit lz_dark(input logic [15:0] v, input int d);
    bit en;
    bit dark;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    en = 1'b1;
`else
    en = 1'b0;
`endif
    dark = en && (d >= 1);
    for (int k = 0; k < ND; k++) begin
      if (k >= d && v[4*k +: 4] != 4'h0) dark = 1'b0;
    end
    return dark;
  endfunction

  // One clock: predict from the model, update the model, compare at negedge.
  task automatic step();
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dpn;
    logic       e_ft;
    int         d;
    @(posedge clk);
    if (rst) begin
      c = 0; m_val = 16'h0; m_blank = 4'hF; m_dp = 4'h0; last_ft = -1;
      e_an = 4'hF; e_seg = 7'h7F; e_dpn = 1'b1; e_ft = 1'b0;
    end else begin
      c = c + 1;
      d = ((c - 1) / DC) % ND;
      if (m_blank[d] || lz_dark(m_val, d)) begin
        e_an = 4'hF; e_seg = 7'h7F; e_dpn = 1'b1;
      end else begin
        e_an  = ~(4'h1 << d);
        e_seg = seg_ref[m_val[4*d +: 4]];
        e_dpn = ~m_dp[d];
      end
      e_ft = (c % FRAME == 0);
      if (e_ft) begin
        m_val = value; m_blank = blank; m_dp = dp;
      end
    end
    @(negedge clk);
    chk("model_an", an, e_an);
    chk("model_seg", seg, e_seg);
    chk("model_dp_n", dp_n, e_dpn);
    chk("model_frame_tick", frame_tick, e_ft);
    if (frame_tick) begin
      chk("ft_back_to_back", prev_ft, 1'b0);
      if (last_ft >= 0) chk("ft_period", c - last_ft, FRAME);
      last_ft = c;
    end
    prev_ft = frame_tick;
  endtask

  task automatic apply(input int i);
    value = tbl[i].value;
    blank = tbl[i].blank;
    dp    = tbl[i].dp;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    seg_ref[0]  = 7'b1000000; seg_ref[1]  = 7'b1111001;
    seg_ref[2]  = 7'b0100100; seg_ref[3]  = 7'b0110000;
    seg_ref[4]  = 7'b0011001; seg_ref[5]  = 7'b0010010;
    seg_ref[6]  = 7'b0000010; seg_ref[7]  = 7'b1111000;
    seg_ref[8]  = 7'b0000000; seg_ref[9]  = 7'b0010000;
    seg_ref[10] = 7'b0001000; seg_ref[11] = 7'b0000011;
    seg_ref[12] = 7'b1000110; seg_ref[13] = 7'b0100001;
    seg_ref[14] = 7'b0000110; seg_ref[15] = 7'b0001110;

    // Slots listed {slot3, slot2, slot1, slot0}.
    tbl[0] = '{16'h1234, 4'b0000, 4'b0000,
               {4'b0111, 4'b1011, 4'b1101, 4'b1110},
               {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'b1111};
    tbl[1] = '{16'hABCD, 4'b0000, 4'b0000,
               {4'b0111, 4'b1011, 4'b1101, 4'b1110},
               {7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001}, 4'b1111};
    tbl[2] = '{16'h1234, 4'b0100, 4'b0001,
               {4'b0111, 4'b1111, 4'b1101, 4'b1110},
               {7'b1111001, 7'b1111111, 7'b0110000, 7'b0011001}, 4'b1110};
`ifdef SEG_LEADING_ZERO_BLANK_EN
    tbl[3] = '{16'h0070, 4'b0000, 4'b0000,
               {4'b1111, 4'b1111, 4'b1101, 4'b1110},
               {7'b1111111, 7'b1111111, 7'b1111000, 7'b1000000}, 4'b1111};
    tbl[4] = '{16'h0000, 4'b0000, 4'b0000,
               {4'b1111, 4'b1111, 4'b1111, 4'b1110},
               {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}, 4'b1111};
`else
    tbl[3] = '{16'h0070, 4'b0000, 4'b0000,
               {4'b0111, 4'b1011, 4'b1101, 4'b1110},
               {7'b1000000, 7'b1000000, 7'b1111000, 7'b1000000}, 4'b1111};
    tbl[4] = '{16'h0000, 4'b0000, 4'b0000,
               {4'b0111, 4'b1011, 4'b1101, 4'b1110},
               {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}, 4'b1111};
`endif
    tbl[5] = '{16'h8F05, 4'b0000, 4'b1010,
               {4'b0111, 4'b1011, 4'b1101, 4'b1110},
               {7'b0000000, 7'b0001110, 7'b1000000, 7'b0010010}, 4'b0101};
    tbl[6] = '{16'hFFFF, 4'b1111, 4'b1111,
               {4'b1111, 4'b1111, 4'b1111, 4'b1111},
               {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111}, 4'b1111};

    // Reset and reset-state checks.
    rst = 1'b1; prev_ft = 1'b0; last_ft = -1; c = 0;
    apply(0);
    step(); step();
    chk("reset_an", an, 4'hF);
    chk("reset_seg", seg, 7'h7F);
    chk("reset_dp_n", dp_n, 1'b1);
    chk("reset_frame_tick", frame_tick, 1'b0);

    // First frame arrives NUM_DIGITS*DIV_COUNT cycles after release.
    rst = 1'b0;
    k = 0;
    while (!frame_tick && k < 40) begin step(); k++; end
    chk("first_frame_latency", k, FRAME);

    // Vector table: next entry is applied mid-frame to check no tearing.
    for (int i = 0; i < NVEC; i++) begin
      k = 0;
      while (!frame_tick && k < 40) begin step(); k++; end
      chk("frame_start_seen", frame_tick, 1'b1);
      for (int s = 0; s < ND; s++) begin
        step();
        chk($sformatf("vec%0d_slot%0d_an", i, s), an, tbl[i].an[s]);
        chk($sformatf("vec%0d_slot%0d_seg", i, s), seg, tbl[i].seg[s]);
        chk($sformatf("vec%0d_slot%0d_dp_n", i, s), dp_n, tbl[i].dpn[s]);
        if (s == 1 && i + 1 < NVEC) apply(i + 1);
        for (int r = 1; r < DC; r++) step();
      end
    end

    // Reset while digit 2 is being scanned.
    apply(0);
    k = 0;
    while (!frame_tick && k < 40) begin step(); k++; end
    for (int r = 0; r < 9; r++) step();
    rst = 1'b1;
    step();
    chk("mid_rst_an", an, 4'hF);
    chk("mid_rst_frame_tick", frame_tick, 1'b0);
    rst = 1'b0;
    k = 0;
    while (!frame_tick && k < 40) begin step(); k++; end
    chk("post_rst_frame_latency", k, FRAME);

    // Randomized phase against the reference model.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        for (int q = 0; q < ND; q++) begin
          value[4*q +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
        end
        blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
        dp    = 4'($urandom);
      end
      rst = ($urandom_range(0, 149) == 0);
      step();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
